// File: rtl/trace_frame_builder.sv
// Packs eight 16-bit trace words into 128-bit frames and queues them in a small FIFO.
// Optional macro TRACE_FRAME_DROPCOUNT_EN builds a saturating dropped-frame counter.
module trace_frame_builder #(
   parameter int FIFO_DEPTH = 4
) (
   input  logic                         traceClkin,
   input  logic                         rst,
   input  logic                         WdAvail,
   input  logic [15:0]                  PacketWd,
   input  logic                         PacketReset,
   output logic                         frame_valid,
   output logic [127:0]                 frame_data,
   input  logic                         frame_ready,
   output logic [$clog2(FIFO_DEPTH):0]  fill,
   output logic                         overflow,
   output logic [15:0]                  drop_count
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int FW = AW + 1;

   typedef enum logic {HUNT = 1'b0, COLLECT = 1'b1} state_t;

   state_t         state_reg, state_next;
   logic           collect_en;
   logic [2:0]     wcnt_reg;
   logic [AW-1:0]  wr_ptr_reg, rd_ptr_reg;
   logic [FW-1:0]  fill_reg;
   logic           overflow_reg;
   logic [127:0]   frame_in;
   logic [127:0]   mem [FIFO_DEPTH];

   logic word_accept, push, pop, full, push_ok, drop;

   always_ff @(posedge traceClkin) begin
      if (rst)
         state_reg <= HUNT;
      else
         state_reg <= state_next;
   end

   always_comb begin
      state_next = state_reg;
      if (PacketReset)
         state_next = COLLECT;
   end

   always_comb begin
      collect_en = (state_reg == COLLECT);
   end

   // PacketReset wins over a coincident word: that word is never stored.
   assign word_accept = collect_en && WdAvail && !PacketReset;
   assign push        = word_accept && (wcnt_reg == 3'd7);
   assign pop         = frame_valid && frame_ready;
   assign full        = (fill_reg == FW'(FIFO_DEPTH));
   assign push_ok     = push && (!full || pop);
   assign drop        = push && full && !pop;

   always_ff @(posedge traceClkin) begin
      if (rst || PacketReset)
         wcnt_reg <= 3'd0;
      else if (word_accept)
         wcnt_reg <= wcnt_reg + 3'd1;
   end

   // Lanes 0..6 are held in registers; lane 7 is the word completing the frame.
   generate
      for (genvar gi = 0; gi < 7; gi++) begin : g_lane
         logic [15:0] lane_reg;
         always_ff @(posedge traceClkin) begin
            if (word_accept && (wcnt_reg == 3'(gi)))
               lane_reg <= PacketWd;
         end
         assign frame_in[16*gi +: 16] = lane_reg;
      end
   endgenerate
   assign frame_in[127:112] = PacketWd;

   always_ff @(posedge traceClkin) begin
      if (push_ok)
         mem[wr_ptr_reg] <= frame_in;
   end

   always_ff @(posedge traceClkin) begin
      if (rst) begin
         wr_ptr_reg   <= '0;
         rd_ptr_reg   <= '0;
         fill_reg     <= '0;
         overflow_reg <= 1'b0;
      end else begin
         if (push_ok)
            wr_ptr_reg <= wr_ptr_reg + AW'(1);
         if (pop)
            rd_ptr_reg <= rd_ptr_reg + AW'(1);
         fill_reg <= fill_reg + FW'(push_ok) - FW'(pop);
         if (drop)
            overflow_reg <= 1'b1;
      end
   end

   assign frame_valid = (fill_reg != '0);
   assign frame_data  = frame_valid ? mem[rd_ptr_reg] : '0;
   assign fill        = fill_reg;
   assign overflow    = overflow_reg;

`ifdef TRACE_FRAME_DROPCOUNT_EN
   logic [15:0] drop_count_reg;

   always_ff @(posedge traceClkin) begin
      if (rst)
         drop_count_reg <= '0;
      else if (drop && (drop_count_reg != 16'hFFFF))
         drop_count_reg <= drop_count_reg + 16'd1;
   end

   assign drop_count = drop_count_reg;
`else
   assign drop_count = 16'd0;
`endif

endmodule

// File: tb/tb_trace_frame_builder.sv
// Bench for trace_frame_builder: directed scenarios plus randomized traffic against a queue model.
module tb_trace_frame_builder;

   localparam int DEPTH = 4;

   logic          traceClkin = 1'b0;
   logic          rst = 1'b1;
   logic          WdAvail = 1'b0;
   logic [15:0]   PacketWd = '0;
   logic          PacketReset = 1'b0;
   logic          frame_valid;
   logic [127:0]  frame_data;
   logic          frame_ready = 1'b0;
   logic [2:0]    fill;
   logic          overflow;
   logic [15:0]   drop_count;

   int n_cmp = 0;
   int n_bad = 0;

   // Reference model: hunting flag, list of partial words, queue of frames
   bit            m_hunt = 1'b1;
   logic [15:0]   m_part[$];
   logic [127:0]  m_fifo[$];
   bit            m_ovf = 1'b0;
   int            m_dc = 0;

   trace_frame_builder #(.FIFO_DEPTH(DEPTH)) dut (
      .traceClkin  (traceClkin),
      .rst         (rst),
      .WdAvail     (WdAvail),
      .PacketWd    (PacketWd),
      .PacketReset (PacketReset),
      .frame_valid (frame_valid),
      .frame_data  (frame_data),
      .frame_ready (frame_ready),
      .fill        (fill),
      .overflow    (overflow),
      .drop_count  (drop_count)
   );

   always #5 traceClkin = ~traceClkin;

   function automatic logic [15:0] exp_dc();
`ifdef TRACE_FRAME_DROPCOUNT_EN
      return 16'(m_dc);
`else
      return 16'd0;
`endif
   endfunction

   // Drive one cycle of inputs, advance the model across the edge, settle 1 time unit.
   task automatic step(input logic wa, input logic [15:0] wd, input logic pr,
                       input logic rdy, input logic r);
      logic [127:0] f;
      bit do_push, do_pop;
      @(negedge traceClkin);
      WdAvail = wa; PacketWd = wd; PacketReset = pr; frame_ready = rdy; rst = r;
      @(posedge traceClkin);
      do_push = 0;
      f = '0;
      if (r) begin
         m_hunt = 1; m_part.delete(); m_fifo.delete(); m_ovf = 0; m_dc = 0;
      end else begin
         do_pop = (m_fifo.size() != 0) && rdy;
         if (pr) begin
            m_hunt = 0;
            m_part.delete();
         end else if (!m_hunt && wa) begin
            m_part.push_back(wd);
            if (m_part.size() == 8) begin
               for (int i = 0; i < 8; i++) f[16*i +: 16] = m_part[i];
               m_part.delete();
               do_push = 1;
            end
         end
         if (do_pop) void'(m_fifo.pop_front());
         if (do_push) begin
            if (m_fifo.size() < DEPTH) m_fifo.push_back(f);
            else begin
               m_ovf = 1;
               if (m_dc < 65535) m_dc++;
            end
         end
      end
      #1;
   endtask

   task automatic send_frame(input logic [127:0] fr, input logic last_rdy);
      for (int i = 0; i < 8; i++)
         step(1'b1, fr[16*i +: 16], 1'b0, (i == 7) ? last_rdy : 1'b0, 1'b0);
   endtask

   task automatic test_reset();
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid got %b want 0", frame_valid); end
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL reset_fill got %0d want 0", fill); end
      n_cmp++; if (overflow !== 1'b0) begin n_bad++; $display("FAIL reset_overflow got %b want 0", overflow); end
      n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL reset_dropcount got %0d want 0", drop_count); end
      n_cmp++; if (frame_data !== 128'd0) begin n_bad++; $display("FAIL reset_data got %h want 0", frame_data); end
      $display("test_reset done");
   endtask

   task automatic test_hunt_discard();
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) step(1'b1, 16'(i + 16'h50), 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL hunt_valid got %b want 0", frame_valid); end
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL hunt_fill got %0d want 0", fill); end
      $display("test_hunt_discard done");
   endtask

   task automatic test_basic_frame();
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 7; i++) step(1'b1, 16'(i), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL basic_early_valid got %b want 0", frame_valid); end
      step(1'b1, 16'h0008, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (frame_valid !== 1'b1) begin n_bad++; $display("FAIL basic_valid got %b want 1", frame_valid); end
      n_cmp++; if (frame_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
         n_bad++; $display("FAIL basic_data got %h want 00080007000600050004000300020001", frame_data); end
      n_cmp++; if (fill !== 3'd1) begin n_bad++; $display("FAIL basic_fill got %0d want 1", fill); end
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (frame_data !== 128'h0008_0007_0006_0005_0004_0003_0002_0001) begin
         n_bad++; $display("FAIL basic_hold got %h", frame_data); end
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL basic_pop_fill got %0d want 0", fill); end
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL basic_empty_ready got %0d want 0", fill); end
      $display("test_basic_frame done");
   endtask

   task automatic test_precedence();
      logic found_a;
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step(1'b1, 16'h0BB0 + 16'(i), 1'b0, 1'b0, 1'b0);
      step(1'b1, 16'hAAAA, 1'b1, 1'b0, 1'b0);
      for (int i = 1; i <= 8; i++) step(1'b1, 16'(i * 16'h1111), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (fill !== 3'd1) begin n_bad++; $display("FAIL prec_fill got %0d want 1", fill); end
      n_cmp++; if (frame_data[15:0] !== 16'h1111) begin n_bad++; $display("FAIL prec_lane0 got %h want 1111", frame_data[15:0]); end
      found_a = 1'b0;
      for (int i = 0; i < 8; i++) if (frame_data[16*i +: 16] === 16'hAAAA) found_a = 1'b1;
      n_cmp++; if (found_a !== 1'b0) begin n_bad++; $display("FAIL prec_no_aaaa got %h want no AAAA lane", frame_data); end
      n_cmp++; if (frame_data !== 128'h8888_7777_6666_5555_4444_3333_2222_1111) begin
         n_bad++; $display("FAIL prec_data got %h want 88887777666655554444333322221111", frame_data); end
      step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      $display("test_precedence done");
   endtask

   task automatic test_overflow_and_full_pushpop();
      logic [127:0] fr[6];
      logic [127:0] nf;
      logic [127:0] exp_q[$];
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int k = 0; k < 6; k++) begin
         fr[k] = {$urandom, $urandom, $urandom, $urandom};
         send_frame(fr[k], 1'b0);
      end
      n_cmp++; if (fill !== 3'd4) begin n_bad++; $display("FAIL ovf_fill got %0d want 4", fill); end
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL ovf_flag got %b want 1", overflow); end
`ifdef TRACE_FRAME_DROPCOUNT_EN
      n_cmp++; if (drop_count !== 16'd2) begin n_bad++; $display("FAIL ovf_dropcount got %0d want 2", drop_count); end
`else
      n_cmp++; if (drop_count !== 16'd0) begin n_bad++; $display("FAIL ovf_dropcount got %0d want 0", drop_count); end
`endif
      n_cmp++; if (frame_data !== fr[0]) begin n_bad++; $display("FAIL ovf_head got %h want %h", frame_data, fr[0]); end
      $display("test_overflow done");

      // New frame whose last word coincides with a pop from the full FIFO
      nf = {$urandom, $urandom, $urandom, $urandom};
      send_frame(nf, 1'b1);
      n_cmp++; if (fill !== 3'd4) begin n_bad++; $display("FAIL fullpp_fill got %0d want 4", fill); end
      n_cmp++; if (drop_count !== exp_dc()) begin n_bad++; $display("FAIL fullpp_dropcount got %0d want %0d", drop_count, exp_dc()); end
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      n_cmp++; if (overflow !== 1'b1) begin n_bad++; $display("FAIL sticky_overflow got %b want 1", overflow); end
      n_cmp++; if (fill !== 3'd4) begin n_bad++; $display("FAIL noflush_fill got %0d want 4", fill); end
      exp_q = {fr[1], fr[2], fr[3], nf};
      for (int k = 0; k < 4; k++) begin
         n_cmp++; if (frame_data !== exp_q[k]) begin n_bad++; $display("FAIL fullpp_pop%0d got %h want %h", k, frame_data, exp_q[k]); end
         $display("pop %0d data %h", k, frame_data);
         step(1'b0, 16'h0, 1'b0, 1'b1, 1'b0);
      end
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL fullpp_drain got %0d want 0", fill); end
      $display("test_full_push_pop done");
   endtask

   task automatic test_mid_reset();
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      step(1'b0, 16'h0, 1'b1, 1'b0, 1'b0);
      for (int i = 0; i < 21; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      n_cmp++; if (fill !== 3'd2) begin n_bad++; $display("FAIL midrst_pre_fill got %0d want 2", fill); end
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL midrst_fill got %0d want 0", fill); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_valid got %b want 0", frame_valid); end
      for (int i = 0; i < 8; i++) step(1'b1, 16'($urandom), 1'b0, 1'b0, 1'b0);
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b0);
      n_cmp++; if (fill !== 3'd0) begin n_bad++; $display("FAIL midrst_hunt_fill got %0d want 0", fill); end
      n_cmp++; if (frame_valid !== 1'b0) begin n_bad++; $display("FAIL midrst_hunt_valid got %b want 0", frame_valid); end
      $display("test_mid_reset done");
   endtask

   task automatic test_random();
      logic wa, pr, rdy, r;
      step(1'b0, 16'h0, 1'b0, 1'b0, 1'b1);
      for (int c = 0; c < 1500; c++) begin
         wa  = ($urandom_range(99) < 75);
         pr  = ($urandom_range(199) < 3);
         rdy = ($urandom_range(99) < 35);
         r   = ($urandom_range(999) < 3);
         step(wa, 16'($urandom), pr, rdy, r);
         n_cmp++; if (fill !== 3'(m_fifo.size())) begin n_bad++; $display("FAIL rand_fill c=%0d got %0d want %0d", c, fill, m_fifo.size()); end
         n_cmp++; if (frame_valid !== (m_fifo.size() != 0)) begin n_bad++; $display("FAIL rand_valid c=%0d got %b", c, frame_valid); end
         n_cmp++; if (overflow !== m_ovf) begin n_bad++; $display("FAIL rand_overflow c=%0d got %b want %b", c, overflow, m_ovf); end
         n_cmp++; if (drop_count !== exp_dc()) begin n_bad++; $display("FAIL rand_dropcount c=%0d got %0d want %0d", c, drop_count, exp_dc()); end
         if (m_fifo.size() != 0) begin
            n_cmp++; if (frame_data !== m_fifo[0]) begin n_bad++; $display("FAIL rand_data c=%0d got %h want %h", c, frame_data, m_fifo[0]); end
         end
      end
      $display("test_random done, model fill %0d overflow %0b", m_fifo.size(), m_ovf);
   endtask

   initial begin
      test_reset();
      test_hunt_discard();
      test_basic_frame();
      test_precedence();
      test_overflow_and_full_pushpop();
      test_mid_reset();
      test_random();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
